// File: rtl/ibex_efpga_pkg.sv
// ibex_efpga_pkg
// Shared types and constants for the core-to-eFPGA bridge.
//   state_e                 : bridge FSM states
//   OP_W / DELAY_W          : operator select and fixed-latency field widths
//   TIMEOUT_CYCLES_DEFAULT  : default WAIT budget in handshake mode
package ibex_efpga_pkg;

    localparam int unsigned OP_W                   = 2;
    localparam int unsigned DELAY_W                = 4;
    localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 1024;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

endpackage

// File: rtl/ibex_efpga_done_sync.sv
// ibex_efpga_done_sync
// Brings the fabric completion flag into the core clock domain through a
// chain of reset-clearable flops. SYNC_STAGES=0 turns it into a wire.
//   clk_i  : core clock
//   rst_ni : asynchronous active-low reset, clears every stage
//   d_i    : raw fabric done (asynchronous)
//   q_o    : synchronized done
module ibex_efpga_done_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    if (SYNC_STAGES == 0) begin : g_bypass
        assign q_o = d_i;
    end else begin : g_sync
        logic [SYNC_STAGES-1:0] sync_r;

        // Shift the raw flag through the synchronizer chain
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                sync_r <= {SYNC_STAGES{1'b0}};
            end else begin
                sync_r[0] <= d_i;
                for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                    sync_r[i] <= sync_r[i-1];
                end
            end
        end

        assign q_o = sync_r[SYNC_STAGES-1];
    end

endmodule

// File: rtl/ibex_efpga_bridge.sv
// ibex_efpga_bridge
// Bridge between the core eFPGA port group and the eFPGA fabric. An accepted
// core write strobe latches operands/operator/delay, a one-cycle start goes
// to the fabric, and completion is either a fixed delay count (delay!=0) or
// a synchronized fabric done guarded by a timeout (delay==0). Results are
// captured and a one-cycle done pulse is returned to the core.
//   core_*  : core side (enable, operands, operator, delay, strobe, done, results)
//   fab_*   : fabric side (operands, operator, start, done, results)
//   busy_o  : high whenever the FSM is not in IDLE
//   timeout_o : sticky, set when the last handshake operation timed out
module ibex_efpga_bridge
    import ibex_efpga_pkg::*;
#(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
    parameter logic [31:0] TIMEOUT_RESULT = 32'hFFFF_FFFF
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               core_en_i,
    input  logic [OP_W-1:0]    core_operator_i,
    input  logic [31:0]        core_operand_a_i,
    input  logic [31:0]        core_operand_b_i,
    input  logic [DELAY_W-1:0] core_delay_i,
    input  logic               core_write_strobe_i,
    output logic               core_done_o,
    output logic [31:0]        core_result_a_o,
    output logic [31:0]        core_result_b_o,
    output logic [31:0]        core_result_c_o,
    output logic [31:0]        fab_operand_a_o,
    output logic [31:0]        fab_operand_b_o,
    output logic [OP_W-1:0]    fab_operator_o,
    output logic               fab_start_o,
    input  logic               fab_done_i,
    input  logic [31:0]        fab_result_a_i,
    input  logic [31:0]        fab_result_b_i,
    input  logic [31:0]        fab_result_c_i,
    output logic               busy_o,
    output logic               timeout_o
);

    localparam int unsigned    TMO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_INIT = TMO_W'(TIMEOUT_CYCLES - 1);

    state_e             state_r;
    logic [DELAY_W-1:0] delay_r;
    logic [DELAY_W-1:0] cnt_r;
    logic [TMO_W-1:0]   tmo_r;
    logic               done_sync_s;

    ibex_efpga_done_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_done_sync (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (fab_done_i),
        .q_o    (done_sync_s)
    );

    // Bridge FSM with all outputs registered; start/done pulses default low
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r         <= IDLE;
            delay_r         <= {DELAY_W{1'b0}};
            cnt_r           <= {DELAY_W{1'b0}};
            tmo_r           <= {TMO_W{1'b0}};
            core_done_o     <= 1'b0;
            core_result_a_o <= 32'h0000_0000;
            core_result_b_o <= 32'h0000_0000;
            core_result_c_o <= 32'h0000_0000;
            fab_operand_a_o <= 32'h0000_0000;
            fab_operand_b_o <= 32'h0000_0000;
            fab_operator_o  <= {OP_W{1'b0}};
            fab_start_o     <= 1'b0;
            busy_o          <= 1'b0;
            timeout_o       <= 1'b0;
        end else begin
            fab_start_o <= 1'b0;
            core_done_o <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (core_en_i && core_write_strobe_i) begin
                        fab_operand_a_o <= core_operand_a_i;
                        fab_operand_b_o <= core_operand_b_i;
                        fab_operator_o  <= core_operator_i;
                        delay_r         <= core_delay_i;
                        timeout_o       <= 1'b0;
                        fab_start_o     <= 1'b1;
                        busy_o          <= 1'b1;
                        state_r         <= ISSUE;
                    end else begin
                        busy_o <= 1'b0;
                    end
                end
                ISSUE: begin
                    if (!core_en_i) begin
                        busy_o  <= 1'b0;
                        state_r <= IDLE;
                    end else begin
                        cnt_r   <= delay_r;
                        tmo_r   <= TMO_INIT;
                        state_r <= WAIT;
                    end
                end
                WAIT: begin
                    if (!core_en_i) begin
                        // Abort: results and timeout flag are left untouched
                        busy_o  <= 1'b0;
                        state_r <= IDLE;
                    end else if (delay_r != {DELAY_W{1'b0}}) begin
                        // Fixed latency: capture on the last counted cycle
                        if (cnt_r == {{(DELAY_W-1){1'b0}}, 1'b1}) begin
                            core_result_a_o <= fab_result_a_i;
                            core_result_b_o <= fab_result_b_i;
                            core_result_c_o <= fab_result_c_i;
                            core_done_o     <= 1'b1;
                            state_r         <= RESP;
                        end else if (cnt_r > {{(DELAY_W-1){1'b0}}, 1'b1}) begin
                            cnt_r <= cnt_r - {{(DELAY_W-1){1'b0}}, 1'b1};
                        end else begin
                            cnt_r <= cnt_r;
                        end
                    end else if (done_sync_s) begin
                        // Done is checked first so it wins over an expiring timeout
                        core_result_a_o <= fab_result_a_i;
                        core_result_b_o <= fab_result_b_i;
                        core_result_c_o <= fab_result_c_i;
                        core_done_o     <= 1'b1;
                        state_r         <= RESP;
                    end else if (tmo_r == {TMO_W{1'b0}}) begin
                        core_result_a_o <= TIMEOUT_RESULT;
                        core_result_b_o <= TIMEOUT_RESULT;
                        core_result_c_o <= TIMEOUT_RESULT;
                        timeout_o       <= 1'b1;
                        core_done_o     <= 1'b1;
                        state_r         <= RESP;
                    end else begin
                        tmo_r <= tmo_r - {{(TMO_W-1){1'b0}}, 1'b1};
                    end
                end
                RESP: begin
                    busy_o  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    busy_o  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ibex_efpga_bridge.sv
// Self-checking bench for ibex_efpga_bridge (SYNC_STAGES=2, TIMEOUT_CYCLES=8).
// A table of operations is applied in a loop; expected results are pushed to
// a scoreboard when the strobe is driven and popped when core_done_o fires.
// Hand-written sequences cover busy strobes, abort, stale done and reset.
module tb_ibex_efpga_bridge;

    localparam int unsigned TB_SYNC = 2;
    localparam int unsigned TB_TMO  = 8;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        core_en_i = 1'b0;
    logic [1:0]  core_operator_i = 2'b00;
    logic [31:0] core_operand_a_i = 32'h0;
    logic [31:0] core_operand_b_i = 32'h0;
    logic [3:0]  core_delay_i = 4'd0;
    logic        core_write_strobe_i = 1'b0;
    logic        core_done_o;
    logic [31:0] core_result_a_o, core_result_b_o, core_result_c_o;
    logic [31:0] fab_operand_a_o, fab_operand_b_o;
    logic [1:0]  fab_operator_o;
    logic        fab_start_o;
    logic        fab_done_i = 1'b0;
    logic [31:0] fab_result_a_i = 32'h0;
    logic [31:0] fab_result_b_i = 32'h0;
    logic [31:0] fab_result_c_i = 32'h0;
    logic        busy_o;
    logic        timeout_o;

    ibex_efpga_bridge #(
        .SYNC_STAGES    (TB_SYNC),
        .TIMEOUT_CYCLES (TB_TMO),
        .TIMEOUT_RESULT (32'hFFFF_FFFF)
    ) dut (
        .clk_i               (clk_i),
        .rst_ni              (rst_ni),
        .core_en_i           (core_en_i),
        .core_operator_i     (core_operator_i),
        .core_operand_a_i    (core_operand_a_i),
        .core_operand_b_i    (core_operand_b_i),
        .core_delay_i        (core_delay_i),
        .core_write_strobe_i (core_write_strobe_i),
        .core_done_o         (core_done_o),
        .core_result_a_o     (core_result_a_o),
        .core_result_b_o     (core_result_b_o),
        .core_result_c_o     (core_result_c_o),
        .fab_operand_a_o     (fab_operand_a_o),
        .fab_operand_b_o     (fab_operand_b_o),
        .fab_operator_o      (fab_operator_o),
        .fab_start_o         (fab_start_o),
        .fab_done_i          (fab_done_i),
        .fab_result_a_i      (fab_result_a_i),
        .fab_result_b_i      (fab_result_b_i),
        .fab_result_c_i      (fab_result_c_i),
        .busy_o              (busy_o),
        .timeout_o           (timeout_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  op;
        logic [3:0]  delay;
        logic [31:0] fra;
        logic [31:0] frb;
        logic [31:0] frc;
        int          done_lat;  // cycles after start when fab_done_i rises, -1 = never
        int          exp_lat;   // expected start-to-core_done cycles
        logic        exp_tmo;
        logic [31:0] era;
        logic [31:0] erb;
        logic [31:0] erc;
    } vec_t;

    typedef struct {
        logic [31:0] ra;
        logic [31:0] rb;
        logic [31:0] rc;
        logic        tmo;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    vec_t vecs[9];
    int   n_cmp  = 0;
    int   n_bad  = 0;
    int   n_done = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                                input logic [3:0] d, input logic [31:0] fra, input logic [31:0] frb,
                                input logic [31:0] frc, input int dl, input int lat, input logic tmo);
        vec_t v;
        v.a = a; v.b = b; v.op = op; v.delay = d;
        v.fra = fra; v.frb = frb; v.frc = frc;
        v.done_lat = dl; v.exp_lat = lat; v.exp_tmo = tmo;
        v.era = tmo ? 32'hFFFF_FFFF : fra;
        v.erb = tmo ? 32'hFFFF_FFFF : frb;
        v.erc = tmo ? 32'hFFFF_FFFF : frc;
        return v;
    endfunction

    // Scoreboard side: every done pulse must match the oldest expectation
    always @(negedge clk_i) begin
        if (core_done_o === 1'b1) begin
            n_done++;
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: got a done pulse, expected none (t=%0t)", $time);
            end else begin
                mon_e = sb_q.pop_front();
                chk("sb_result_a", core_result_a_o, mon_e.ra);
                chk("sb_result_b", core_result_b_o, mon_e.rb);
                chk("sb_result_c", core_result_c_o, mon_e.rc);
                chk("sb_timeout", {31'b0, timeout_o}, {31'b0, mon_e.tmo});
            end
        end
    end

    task automatic drive_strobe(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                                input logic [3:0] d);
        @(posedge clk_i); #1;
        core_en_i = 1'b1;
        core_write_strobe_i = 1'b1;
        core_operand_a_i = a;
        core_operand_b_i = b;
        core_operator_i = op;
        core_delay_i = d;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int  k;
        bit  seen;
        exp_t e;
        fab_result_a_i = v.fra;
        fab_result_b_i = v.frb;
        fab_result_c_i = v.frc;
        drive_strobe(v.a, v.b, v.op, v.delay);
        e.ra = v.era; e.rb = v.erb; e.rc = v.erc; e.tmo = v.exp_tmo;
        sb_q.push_back(e);
        @(posedge clk_i); #1;
        core_write_strobe_i = 1'b0;
        core_operand_a_i = ~v.a;        // operands to the fabric must stay latched
        core_operand_b_i = ~v.b;
        core_operator_i = ~v.op;
        @(negedge clk_i);
        chk({tag, "_start"}, {31'b0, fab_start_o}, 32'd1);
        chk({tag, "_fab_a"}, fab_operand_a_o, v.a);
        chk({tag, "_fab_b"}, fab_operand_b_o, v.b);
        chk({tag, "_fab_op"}, {30'b0, fab_operator_o}, {30'b0, v.op});
        chk({tag, "_busy"}, {31'b0, busy_o}, 32'd1);
        chk({tag, "_tmo_clr"}, {31'b0, timeout_o}, 32'd0);
        seen = 1'b0;
        k = 0;
        while (!seen && k < 40) begin
            @(posedge clk_i); #1;
            k++;
            if (k == v.done_lat) fab_done_i = 1'b1;
            @(negedge clk_i);
            if (k == 1) chk({tag, "_start_pulse"}, {31'b0, fab_start_o}, 32'd0);
            if (core_done_o === 1'b1) seen = 1'b1;
        end
        chk({tag, "_latency"}, k, v.exp_lat);
        @(posedge clk_i); #1;
        fab_done_i = 1'b0;
        @(negedge clk_i);
        chk({tag, "_done_pulse"}, {31'b0, core_done_o}, 32'd0);
        chk({tag, "_idle"}, {31'b0, busy_o}, 32'd0);
        chk({tag, "_tmo_sticky"}, {31'b0, timeout_o}, {31'b0, v.exp_tmo});
        repeat (3) @(posedge clk_i);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int           d0;
        int           bad_start;
        logic [31:0]  held_a;
        exp_t         e;

        vecs[0] = mk(32'h1234_5678, 32'h9ABC_DEF0, 2'b01, 4'd3,  32'h1, 32'h2, 32'h3, -1, 4, 1'b0);
        vecs[1] = mk(32'hA5A5_A5A5, 32'h5A5A_5A5A, 2'b10, 4'd1,  32'h1111_1111, 32'h2222_2222, 32'h3333_3333, -1, 2, 1'b0);
        vecs[2] = mk(32'hDEAD_BEEF, 32'hCAFE_F00D, 2'b11, 4'd15, 32'h0BAD_F00D, 32'hFEED_FACE, 32'h1357_9BDF, 2, 16, 1'b0);
        vecs[3] = mk(32'h0000_0001, 32'h0000_0002, 2'b00, 4'd0,  32'h4444_4444, 32'h5555_5555, 32'h6666_6666, 4, 7, 1'b0);
        vecs[4] = mk(32'h0F0F_0F0F, 32'hF0F0_F0F0, 2'b01, 4'd0,  32'h7777_7777, 32'h8888_8888, 32'h9999_9999, 1, 4, 1'b0);
        vecs[5] = mk(32'h1111_0000, 32'h0000_1111, 2'b10, 4'd0,  32'hAAAA_AAAA, 32'hBBBB_BBBB, 32'hCCCC_CCCC, -1, 9, 1'b1);
        vecs[6] = mk(32'h2222_0000, 32'h0000_2222, 2'b11, 4'd0,  32'h0102_0304, 32'h0506_0708, 32'h090A_0B0C, 2, 5, 1'b0);
        vecs[7] = mk(32'h3333_0000, 32'h0000_3333, 2'b00, 4'd0,  32'hC0DE_0001, 32'hC0DE_0002, 32'hC0DE_0003, 6, 9, 1'b0);
        vecs[8] = mk(32'h4444_0000, 32'h0000_4444, 2'b01, 4'd0,  32'hD00D_0001, 32'hD00D_0002, 32'hD00D_0003, 7, 9, 1'b1);

        // Reset state
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_done", {31'b0, core_done_o}, 32'd0);
        chk("rst_start", {31'b0, fab_start_o}, 32'd0);
        chk("rst_busy", {31'b0, busy_o}, 32'd0);
        chk("rst_timeout", {31'b0, timeout_o}, 32'd0);
        chk("rst_result_a", core_result_a_o, 32'h0);
        chk("rst_fab_a", fab_operand_a_o, 32'h0);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        repeat (2) @(posedge clk_i);

        for (int i = 0; i < 9; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Busy strobe: a second strobe during WAIT is dropped
        fab_result_a_i = 32'hABCD_0001;
        fab_result_b_i = 32'hABCD_0002;
        fab_result_c_i = 32'hABCD_0003;
        d0 = n_done;
        drive_strobe(32'hCAFE_0001, 32'hCAFE_0002, 2'b01, 4'd4);
        e.ra = 32'hABCD_0001; e.rb = 32'hABCD_0002; e.rc = 32'hABCD_0003; e.tmo = 1'b0;
        sb_q.push_back(e);
        @(posedge clk_i); #1;
        core_write_strobe_i = 1'b0;
        @(posedge clk_i); #1;
        core_write_strobe_i = 1'b1;
        core_operand_a_i = 32'hBAD0_BAD0;
        core_operand_b_i = 32'hBAD1_BAD1;
        core_operator_i = 2'b10;
        @(posedge clk_i); #1;
        core_write_strobe_i = 1'b0;
        @(negedge clk_i);
        chk("busy_fab_a", fab_operand_a_o, 32'hCAFE_0001);
        chk("busy_fab_op", {30'b0, fab_operator_o}, 32'd1);
        repeat (20) @(posedge clk_i);
        @(negedge clk_i);
        chk("busy_done_count", n_done - d0, 32'd1);
        chk("busy_fab_a_after", fab_operand_a_o, 32'hCAFE_0001);
        chk("busy_idle", {31'b0, busy_o}, 32'd0);

        // Abort: dropping core_en_i mid-WAIT returns to IDLE with no done
        d0 = n_done;
        held_a = core_result_a_o;
        fab_result_a_i = 32'h5151_5151;
        drive_strobe(32'h0A0A_0A0A, 32'h0B0B_0B0B, 2'b11, 4'd0);
        @(posedge clk_i); #1;
        core_write_strobe_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        core_en_i = 1'b0;
        @(negedge clk_i);
        chk("abort_busy_wait", {31'b0, busy_o}, 32'd1);
        @(negedge clk_i);
        chk("abort_busy_idle", {31'b0, busy_o}, 32'd0);
        repeat (15) @(posedge clk_i);
        @(negedge clk_i);
        chk("abort_no_done", n_done - d0, 32'd0);
        chk("abort_result_a", core_result_a_o, held_a);
        chk("abort_timeout", {31'b0, timeout_o}, 32'd0);

        // Stale fab_done_i and a strobe with core_en_i low, both in IDLE
        d0 = n_done;
        bad_start = 0;
        @(posedge clk_i); #1;
        fab_done_i = 1'b1;
        core_write_strobe_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_i);
            if (fab_start_o !== 1'b0 || busy_o !== 1'b0) bad_start++;
        end
        @(posedge clk_i); #1;
        fab_done_i = 1'b0;
        core_write_strobe_i = 1'b0;
        chk("idle_ignore_activity", bad_start, 32'd0);
        chk("idle_ignore_done", n_done - d0, 32'd0);
        repeat (4) @(posedge clk_i);

        // Reset mid-WAIT clears everything at once and suppresses the done
        d0 = n_done;
        drive_strobe(32'h7E7E_7E7E, 32'h8E8E_8E8E, 2'b10, 4'd0);
        @(posedge clk_i); #1;
        core_write_strobe_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1'b0;
        #1;
        chk("mrst_busy", {31'b0, busy_o}, 32'd0);
        chk("mrst_result_a", core_result_a_o, 32'h0);
        chk("mrst_result_c", core_result_c_o, 32'h0);
        chk("mrst_fab_a", fab_operand_a_o, 32'h0);
        chk("mrst_fab_b", fab_operand_b_o, 32'h0);
        chk("mrst_fab_op", {30'b0, fab_operator_o}, 32'd0);
        chk("mrst_done", {31'b0, core_done_o}, 32'd0);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        repeat (12) @(posedge clk_i);
        @(negedge clk_i);
        chk("mrst_no_done", n_done - d0, 32'd0);

        // Recovery after reset
        run_vec(vecs[3], "post_rst");

        chk("sb_empty", sb_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
